// File: rtl/handshake_fifo_opaque_pkg.sv
// Shared handshake definitions: operation encoding and width helpers used to
// size FIFO pointers and occupancy counters for arbitrary slot counts.
package handshake_fifo_opaque_pkg;

    // Combined handshake event seen in one cycle, encoded as {push, pop}
    typedef enum logic [1:0] {
        HS_IDLE = 2'b00,
        HS_POP  = 2'b01,
        HS_PUSH = 2'b10,
        HS_BOTH = 2'b11
    } hs_op_e;

    // Number of bits needed to index 'value' distinct items (ceil(log2(value)))
    function automatic int clog2_f(input int value);
        int result;
        int remain;
        result = 32'sd0;
        remain = value - 32'sd1;
        while (remain > 32'sd0) begin
            result = result + 32'sd1;
            remain = remain >>> 32'sd1;
        end
        return result;
    endfunction

    // Pointer width: at least one bit so a single-slot FIFO still has a legal index
    function automatic int ptr_width_f(input int num_slots);
        int width;
        width = clog2_f(num_slots);
        return (width < 32'sd1) ? 32'sd1 : width;
    endfunction

    // Counter width: must represent every occupancy from 0 up to num_slots inclusive
    function automatic int cnt_width_f(input int num_slots);
        return clog2_f(num_slots + 32'sd1);
    endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// Token storage array: synchronous write, asynchronous read. No reset on the
// contents; validity of each slot is tracked by the controlling FIFO.
module handshake_fifo_mem
    import handshake_fifo_opaque_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 2,
    parameter int PTR_W      = ptr_width_f(NUM_SLOTS)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [NUM_SLOTS];

    // Capture an incoming token into the addressed slot
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Present the addressed slot without a clock delay
    always_comb begin
        rd_data = mem_r[rd_addr];
    end

endmodule

// File: rtl/handshake_fifo_opaque.sv
// Opaque elastic FIFO: both valid and ready are derived only from registered
// state, so the buffer breaks combinational handshake loops between a
// producer and its consumer. Input-to-output latency is always one cycle.
module handshake_fifo_opaque
    import handshake_fifo_opaque_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int PTR_W = ptr_width_f(NUM_SLOTS);
    localparam int CNT_W = cnt_width_f(NUM_SLOTS);

    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(NUM_SLOTS - 32'sd1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NUM_SLOTS);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);

    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [CNT_W-1:0]      count_r;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic                  valid_s;
    logic                  ready_s;
    logic                  push_s;
    logic                  pop_s;
    hs_op_e                op_s;

    // Pointers wrap by explicit compare so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] ptr_next_f(input logic [PTR_W-1:0] ptr);
        if (ptr == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_ONE;
        end
    endfunction

    handshake_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SLOTS  (NUM_SLOTS),
        .PTR_W      (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_s),
        .wr_addr (tail_r),
        .wr_data (ins),
        .rd_addr (head_r),
        .rd_data (rd_data_s)
    );

    // Handshake status from registered occupancy only; both sides held off during reset
    always_comb begin
        valid_s = rst & (count_r != {CNT_W{1'b0}});
        ready_s = rst & (count_r != FULL_COUNT);
        push_s  = ins_valid & ready_s;
        pop_s   = valid_s & outs_ready;
        op_s    = hs_op_e'({push_s, pop_s});
    end

    // Drive the consumer side, gating data to zero whenever no token is offered
    always_comb begin
        ins_ready  = ready_s;
        outs_valid = valid_s;
        if (valid_s) begin
            outs = rd_data_s;
        end else begin
            outs = {DATA_WIDTH{1'b0}};
        end
    end

    // Pointer and occupancy state; reset discards every stored token
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= ptr_next_f(tail_r);
            end
            if (pop_s) begin
                head_r <= ptr_next_f(head_r);
            end
            case (op_s)
                HS_PUSH: count_r <= count_r + CNT_ONE;
                HS_POP:  count_r <= count_r - CNT_ONE;
                HS_BOTH: count_r <= count_r;
                HS_IDLE: count_r <= count_r;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_fifo_opaque.sv
// Self-checking bench: two FIFOs (2 and 3 slots) driven side by side and
// compared every cycle against a queue-based model of an opaque FIFO.
module tb_handshake_fifo_opaque;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [31:0] din0 = 32'd0, dout0;
    logic        iv0 = 1'b0, ir0, ov0, or0 = 1'b0;
    logic [31:0] din1 = 32'd0, dout1;
    logic        iv1 = 1'b0, ir1, ov1, or1 = 1'b0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] log0[$];
    logic [31:0] log1[$];
    bit          pushed1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    handshake_fifo_opaque #(.DATA_WIDTH(32), .NUM_SLOTS(2)) dut2 (
        .clk(clk), .rst(rst), .ins(din0), .ins_valid(iv0), .ins_ready(ir0),
        .outs(dout0), .outs_valid(ov0), .outs_ready(or0)
    );

    handshake_fifo_opaque #(.DATA_WIDTH(32), .NUM_SLOTS(3)) dut3 (
        .clk(clk), .rst(rst), .ins(din1), .ins_valid(iv1), .ins_ready(ir1),
        .outs(dout1), .outs_valid(ov1), .outs_ready(or1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: decide transfers from model state, advance the model, compare outputs
    task automatic tick();
        bit push0, pop0, push1, pop1;
        push0 = rst && iv0 && (q0.size() < 2);
        pop0  = rst && or0 && (q0.size() > 0);
        push1 = rst && iv1 && (q1.size() < 3);
        pop1  = rst && or1 && (q1.size() > 0);
        if (ov0 && or0) log0.push_back(dout0);
        if (ov1 && or1) log1.push_back(dout1);
        @(posedge clk);
        if (!rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (pop0)  void'(q0.pop_front());
            if (push0) q0.push_back(din0);
            if (pop1)  void'(q1.pop_front());
            if (push1) q1.push_back(din1);
        end
        pushed1 = push1;
        #1;
        chk("ready2", {31'd0, ir0}, {31'd0, rst && (q0.size() < 2)});
        chk("valid2", {31'd0, ov0}, {31'd0, rst && (q0.size() > 0)});
        chk("data2",  dout0, (rst && q0.size() > 0) ? q0[0] : 32'd0);
        chk("ready3", {31'd0, ir1}, {31'd0, rst && (q1.size() < 3)});
        chk("valid3", {31'd0, ov1}, {31'd0, rst && (q1.size() > 0)});
        chk("data3",  dout1, (rst && q1.size() > 0) ? q1[0] : 32'd0);
    endtask

    initial begin
        logic [31:0] exp_d [4];
        int          next_tok;
        int          budget;

        // 1. reset held with a token offered
        rst = 1'b0; iv0 = 1'b1; din0 = 32'h1; iv1 = 1'b1; din1 = 32'h1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", {30'd0, ir0, ir1}, 32'd0);
            chk("rst_valid", {30'd0, ov0, ov1}, 32'd0);
            chk("rst_outs",  dout0 | dout1, 32'd0);
        end
        iv0 = 1'b0; iv1 = 1'b0;
        rst = 1'b1;
        #1;
        chk("post_rst_ready", {30'd0, ir0, ir1}, 32'd3);
        chk("post_rst_valid", {30'd0, ov0, ov1}, 32'd0);
        tick();

        // 2. single token stall then pop, 2 slots
        iv0 = 1'b1; din0 = 32'h1; or0 = 1'b0;
        tick();
        iv0 = 1'b0; din0 = 32'h0;
        chk("single_valid", {31'd0, ov0}, 32'd1);
        chk("single_outs", dout0, 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_outs", dout0, 32'h1);
            chk("stall_valid", {31'd0, ov0}, 32'd1);
        end
        or0 = 1'b1;
        tick();
        chk("popped_valid", {31'd0, ov0}, 32'd0);
        or0 = 1'b0;

        // 3. fill to full, 3 slots, then push while draining
        log1.delete();
        or1 = 1'b0;
        exp_d[0] = 32'hA; exp_d[1] = 32'hB; exp_d[2] = 32'hC; exp_d[3] = 32'hD;
        for (int i = 0; i < 3; i++) begin
            iv1 = 1'b1; din1 = exp_d[i];
            tick();
        end
        chk("full_ready", {31'd0, ir1}, 32'd0);
        or1 = 1'b1; iv1 = 1'b1; din1 = 32'hD;
        #1;
        chk("full_no_bypass_ready", {31'd0, ir1}, 32'd0);
        tick();
        chk("freed_ready", {31'd0, ir1}, 32'd1);
        tick();
        iv1 = 1'b0; din1 = 32'd0;
        for (int i = 0; i < 4; i++) tick();
        or1 = 1'b0;
        chk("full_log_len", log1.size(), 32'd4);
        for (int i = 0; i < 4; i++) chk("full_order", (i < log1.size()) ? log1[i] : 32'hDEAD, exp_d[i]);

        // 4. streaming at full rate, 2 slots
        log0.delete();
        iv0 = 1'b1; or0 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            din0 = i;
            tick();
            chk("stream_outs", dout0, i);
            chk("stream_ready", {31'd0, ir0}, 32'd1);
        end
        iv0 = 1'b0;
        tick();
        or0 = 1'b0;
        chk("stream_len", log0.size(), 32'd100);
        for (int i = 0; i < 100; i++) chk("stream_seq", (i < log0.size()) ? log0[i] : 32'hDEAD, i);

        // 5. random valid/ready across pointer wrap, 3 slots
        log1.delete();
        next_tok = 0;
        budget = 0;
        while (log1.size() < 1000 && budget < 20000) begin
            iv1  = (next_tok < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            or1  = 1'($urandom_range(0, 1));
            din1 = next_tok;
            tick();
            if (pushed1) next_tok++;
            budget++;
        end
        iv1 = 1'b0; or1 = 1'b0;
        chk("wrap_count", log1.size(), 32'd1000);
        for (int i = 0; i < 1000; i++) chk("wrap_seq", (i < log1.size()) ? log1[i] : 32'hDEAD, i);

        // 6. reset with two tokens stored
        log0.delete();
        iv0 = 1'b1; or0 = 1'b0;
        din0 = 32'h11; tick();
        din0 = 32'h22; tick();
        iv0 = 1'b0;
        chk("pre_rst_full", {31'd0, ir0}, 32'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", {31'd0, ov0}, 32'd0);
        iv0 = 1'b1; din0 = 32'h5;
        tick();
        iv0 = 1'b0; or0 = 1'b1;
        tick();
        tick();
        or0 = 1'b0;
        chk("mid_rst_len", log0.size(), 32'd1);
        chk("mid_rst_first", (log0.size() > 0) ? log0[0] : 32'hDEAD, 32'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
